// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory and buffers returned words for IF/ID.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  entry_t           r_mem [DEPTH];

  logic [CNT_W:0]   w_inflight;
  logic             w_credit;
  logic             w_req_fire;
  logic             w_rsp_ok;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head;

  // Credits cover both buffered entries and in-flight requests, so a response
  // always finds a free FIFO slot.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit   = w_inflight < (CNT_W + 1)'(DEPTH);

  // The request is also gated by reset so it drops the instant reset asserts,
  // not at the next edge.
  assign imem_req_valid = reset && w_credit && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_rsp_ok   = imem_rsp_valid && (r_outstanding != '0);
  assign w_push     = w_rsp_ok && !redirect_valid && (r_drop_cnt == '0);
  assign w_pop      = (r_count != '0) && !stall && !redirect_valid;

  assign w_head      = r_mem[r_rd_ptr];
  assign if_valid    = (r_count != '0);
  assign if_instr    = if_valid ? w_head.instr    : 32'h0;
  assign if_pc_plus4 = if_valid ? w_head.pc_plus4 : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      case ({w_req_fire, w_rsp_ok})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (redirect_valid) begin
        // Everything still in flight belongs to the old path, including a
        // response that lands in this very cycle.
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_drop_cnt <= r_outstanding - CNT_W'(w_rsp_ok);
        r_count    <= '0;
        r_rd_ptr   <= r_wr_ptr;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;

        if (w_rsp_ok) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
          else                  r_rsp_pc   <= r_rsp_pc + 32'd4;
        end

        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: the entry storage is deliberately not reset; r_count qualifies every
  // read, so stale contents are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc_plus4: r_rsp_pc + 32'd4, instr: imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a latency-programmable memory model
// feeds the DUT while a scoreboard queue holds the expected delivery stream.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int cyc   = 0;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [63:0] exp_q   [$];

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Expected delivery stream for a sequential path starting at base.
  task automatic push_path(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({base + 32'(4 * i) + 32'd4, instr_of(base + 32'(4 * i))});
    end
  endtask

  // Hold reset two edges, release just after an edge: caller is then in cycle 0.
  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    push_path(32'h0, 64);
  endtask

  task automatic wait_if_valid(input string tag, input int budget);
    int n = 0;
    while (!if_valid && n < budget) begin
      tick();
      to_neg();
      n++;
    end
    check(tag, 32'(if_valid), 32'd1);
  endtask

  // Memory model: in-order, fixed latency per request, cleared by reset.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset && imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        mq_addr.delete();
        mq_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Scoreboard: every pop is compared against the head of the expected stream.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      tests++;
      assert (int'(dut.r_count) + int'(dut.r_outstanding) <= DEPTH) else begin
        fails++;
        $error("FAIL credit_limit: observed %0d expected <= %0d",
               int'(dut.r_count) + int'(dut.r_outstanding), DEPTH);
      end
      if (reset && if_valid && !stall && !redirect_valid) begin
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_pop: observed pc_plus4 %0h expected no entry", if_pc_plus4);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pop_pc_plus4", if_pc_plus4, e[63:32]);
          check("pop_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    int nreq;
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;

    // Reset state
    repeat (2) tick();
    to_neg();
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Streaming with 1-cycle memory
    lat = 1;
    tick();
    reset = 1'b1;
    push_path(32'h0, 64);
    to_neg();
    check("t1_c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_c0_addr", imem_req_addr, 32'h0);
    check("t1_c0_if_valid", 32'(if_valid), 32'd0);
    tick(); to_neg();
    check("t1_c1_addr", imem_req_addr, 32'h4);
    check("t1_c1_if_valid", 32'(if_valid), 32'd0);
    tick(); to_neg();
    check("t1_c2_if_valid", 32'(if_valid), 32'd1);
    check("t1_c2_pc_plus4", if_pc_plus4, 32'h4);
    for (int k = 3; k < 10; k++) begin
      tick(); to_neg();
      check("t1_stream_valid", 32'(if_valid), 32'd1);
      check("t1_stream_addr", imem_req_addr, 32'(4 * k));
      check("t1_stream_pc_plus4", if_pc_plus4, 32'(4 * (k - 1)));
    end

    // Stall fills the FIFO up to the credit limit
    stall = 1'b1;
    do_reset();
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      to_neg();
      if (imem_req_valid && imem_req_ready) nreq++;
      if (k >= 2) begin
        check("t2_head_pc_plus4", if_pc_plus4, 32'h4);
        check("t2_head_instr", if_instr, instr_of(32'h0));
      end
      if (k == 9) check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
      tick();
    end
    check("t2_req_count", 32'(nreq), 32'(DEPTH));
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      to_neg();
      check("t2_drain_valid", 32'(if_valid), 32'd1);
      check("t2_drain_pc_plus4", if_pc_plus4, 32'(4 * (i + 1)));
      tick();
    end

    // Redirect with two stale responses in flight (latency 3)
    lat = 3;
    do_reset();
    to_neg();
    tick(); to_neg();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    push_path(32'h100, 64);
    to_neg();
    check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    to_neg();
    check("t3_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
    check("t3_new_addr", imem_req_addr, 32'h100);
    wait_if_valid("t3_if_valid_timeout", 20);
    check("t3_first_pc_plus4", if_pc_plus4, 32'h104);
    check("t3_first_instr", if_instr, instr_of(32'h100));

    // Redirect coinciding with a response and a pending pop (latency 2)
    lat = 2;
    do_reset();
    to_neg();
    tick(); to_neg();
    tick(); to_neg();
    check("t4_c2_if_valid", 32'(if_valid), 32'd0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    push_path(32'h300, 64);
    to_neg();
    check("t4_pending_pop", 32'(if_valid), 32'd1);
    check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    to_neg();
    check("t4_fetch_addr", imem_req_addr, 32'h300);
    check("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check("t4_drop_cnt", 32'(dut.r_drop_cnt), 32'd1);
    check("t4_flushed", 32'(if_valid), 32'd0);
    wait_if_valid("t4_if_valid_timeout", 20);
    check("t4_first_pc_plus4", if_pc_plus4, 32'h304);

    // Memory not ready: request holds, then a redirect retargets it
    lat = 1;
    imem_req_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      to_neg();
      check("t5_hold_valid", 32'(imem_req_valid), 32'd1);
      check("t5_hold_addr", imem_req_addr, 32'h0);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    push_path(32'h400, 64);
    to_neg();
    check("t5_redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    to_neg();
    check("t5_retarget_addr", imem_req_addr, 32'h400);
    check("t5_retarget_valid", 32'(imem_req_valid), 32'd1);
    tick();
    imem_req_ready = 1'b1;
    to_neg();
    wait_if_valid("t5_if_valid_timeout", 20);
    check("t5_first_pc_plus4", if_pc_plus4, 32'h404);
    repeat (4) begin tick(); to_neg(); end

    // Address wrap-around
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    push_path(32'hFFFF_FFFC, 64);
    to_neg();
    tick();
    redirect_valid = 1'b0;
    to_neg();
    check("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    check("t6_req_valid", 32'(imem_req_valid), 32'd1);
    tick(); to_neg();
    check("t6_addr_wrap", imem_req_addr, 32'h0);
    wait_if_valid("t6_if_valid_timeout", 20);
    check("t6_top_pc_plus4", if_pc_plus4, 32'h0);
    check("t6_top_instr", if_instr, instr_of(32'hFFFF_FFFC));
    tick(); to_neg();
    check("t6_next_pc_plus4", if_pc_plus4, 32'h4);
    repeat (3) begin tick(); to_neg(); end

    // Asynchronous reset mid-stream, between clock edges
    @(posedge clk);
    #3;
    check("t7_pre_if_valid", 32'(if_valid), 32'd1);
    check("t7_pre_req_valid", 32'(imem_req_valid), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t7_async_if_valid", 32'(if_valid), 32'd0);
    check("t7_async_req_valid", 32'(imem_req_valid), 32'd0);
    check("t7_async_pc_plus4", if_pc_plus4, 32'h0);
    tick(); tick();
    reset = 1'b1;
    push_path(32'h0, 64);
    to_neg();
    check("t7_restart_addr", imem_req_addr, 32'h0);
    tick(); to_neg();
    tick(); to_neg();
    check("t7_restart_valid", 32'(if_valid), 32'd1);
    check("t7_restart_pc_plus4", if_pc_plus4, 32'h4);
    repeat (3) begin tick(); to_neg(); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Replaces the bare PC register, PC adder and instruction-memory path in front of the IF/ID pipe.
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory through a valid/ready handshake.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO, and hands {pc+4, instruction} to the IF/ID register under a stall signal.
- Handles branch/jump redirects from decode by flushing the FIFO and discarding wrong-path responses still in flight.

Parameters:
DEPTH, 4, prefetch FIFO entries and maximum requests in flight; power of two, at least 2.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low; clears all state immediately.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch byte address (word aligned).
imem_req_ready  input  1  memory accepts the request this cycle.
imem_rsp_valid  input  1  instruction returned this cycle; responses arrive in request order.
imem_rsp_data  input  32  returned instruction word.
redirect_valid  input  1  decode-stage branch taken or jump; one-cycle pulse.
redirect_pc  input  32  new fetch target.
stall  input  1  IF/ID cannot accept this cycle.
if_valid  output  1  head entry is valid.
if_instr  output  32  head instruction.
if_pc_plus4  output  32  address of head instruction + 4.

Behaviour:
- State registers:
  - fetch_pc (next request address).
  - rsp_pc (address of next kept response).
  - outstanding (requests accepted, response not yet seen; 0..DEPTH).
  - drop_cnt (in-flight responses to discard).
  - FIFO: count, rd_ptr, wr_ptr.
- Reset (reset=0, async): fetch_pc=rsp_pc=RESET_PC; all counters and pointers 0; if_valid=0, if_instr=0, if_pc_plus4=0, imem_req_valid=0.
- Request issue:
  - imem_req_valid = (count + outstanding < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4, wrapping mod 2^32, and outstanding += 1.
  - Once asserted, imem_req_valid and imem_req_addr stay stable until ready, except when a redirect retracts the request.
- Response:
  - On imem_rsp_valid, outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise: push {rsp_pc+4, imem_rsp_data} into the FIFO and rsp_pc += 4.
  - A response while outstanding == 0 is ignored and leaves no counter change.
  - Request and response in the same cycle: outstanding is unchanged.
- Invariant: count + outstanding <= DEPTH at all times, so a push never finds the FIFO full. The bench asserts this.
- Output:
  - if_valid = (count != 0); if_instr and if_pc_plus4 come from the head entry.
  - All three outputs read 0 while the FIFO is empty.
  - Pop when if_valid && !stall && !redirect_valid.
  - A pushed entry becomes visible the next cycle; there is no combinational bypass. Minimum latency from request to if_valid is memory latency + 1 cycle.
  - Simultaneous push and pop: count is unchanged and pointers wrap mod DEPTH.
- Redirect (redirect_valid=1):
  - No request is issued and no pop occurs.
  - FIFO is cleared: count=0, rd_ptr=wr_ptr.
  - fetch_pc and rsp_pc are set to redirect_pc.
  - drop_cnt is set to outstanding − imem_rsp_valid. Any response arriving in the redirect cycle is itself discarded.
  - outstanding keeps counting, so requests to the new path are gated until credits are free: count + outstanding < DEPTH still governs issue.
  - A redirect in consecutive cycles is legal; the second simply re-targets.
- Stall holds the head entry and its outputs stable; prefetch continues until the credit limit is reached.
- Reset asserted mid-operation drops all entries and in-flight state. Memory is reset on the same net, so no stale responses follow.

Test Plan:
- Reset release, 1-cycle memory, ready=1, stall=0:
  - Request addresses are 0x0, 0x4, 0x8, ….
  - if_valid first rises 2 cycles after reset release, with if_pc_plus4=0x4; one instruction is delivered per cycle thereafter.
- stall held high for 10 cycles, memory latency 1:
  - Exactly DEPTH=4 requests issue, then imem_req_valid=0.
  - The head holds instr@0x0 throughout.
  - After release, entries pop in order 0x0..0xC with no gaps or duplicates.
- Memory latency 3 with 2 requests in flight, then redirect_pc=0x100:
  - Both stale responses are dropped.
  - The next if_valid entry has if_pc_plus4=0x104 and the instr@0x100 word.
  - count + outstanding never exceeds 4.
- Redirect asserted in the same cycle as a response and a pending pop:
  - The response is discarded and no pop occurs.
  - fetch_pc=redirect_pc next cycle; drop_cnt = outstanding − 1.
- imem_req_ready held low for 5 cycles:
  - imem_req_addr holds stable at the pending address.
  - A redirect during this window changes imem_req_addr to redirect_pc the next cycle.
- Wrap-around and async reset:
  - A redirect to 0xFFFF_FFFC fetches 0xFFFF_FFFC then 0x0000_0000.
  - Asserting reset mid-stream clears if_valid and imem_req_valid within the same cycle, without waiting for a clock edge.
